bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: NREQ, 3, number of requesters (0=IFU, 1=MEMU, 2=MMU).
REQ-002 Parameter: TIMEOUT, 255, max WAIT cycles before error response (8-bit).
REQ-003 Ports, one per line (name  direction  width  meaning); reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous active-low
- req_valid  in  NREQ  per-requester request; held until matching resp_valid
- req_addr  in  NREQ*64  request address, slice i belongs to requester i
- req_wen  in  NREQ  1=write, 0=read
- req_wdata  in  NREQ*64  write data
- req_strb  in  NREQ*8  write byte strobes
- resp_valid  out  NREQ  one-hot response strobe
- resp_data  out  64  read data, valid with resp_valid
- resp_err  out  1  timeout error, valid with resp_valid
- grant_id  out  2  index of current owner; 3 when idle
- m_valid  out  1  downstream request valid
- m_addr / m_wen / m_wdata / m_strb  out  64/1/64/8  latched request fields
- m_ready  in  1  downstream accepts request
- m_resp_valid  in  1  downstream response
- m_resp_data  in  64  downstream read data

Function
REQ-004 FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-005 IDLE: if any req_valid, select winner, latch its addr/wen/wdata/strb into m_* registers, set grant_id, go ISSUE next edge; else stay IDLE.
REQ-006 Fixed priority when REQ-020 macro absent: 2 > 1 > 0.
REQ-007 ISSUE: m_valid=1; on m_valid&m_ready edge go WAIT and clear timeout counter.
REQ-008 m_* fields SHALL stay stable while m_valid=1 and m_ready=0.
REQ-009 WAIT: resp_valid[grant_id]=m_resp_valid (combinational), resp_data=m_resp_data, resp_err=0; on that edge go IDLE.
REQ-010 WAIT: counter increments each cycle without m_resp_valid; when counter reaches TIMEOUT, resp_valid[grant_id]=1, resp_data=0, resp_err=1 for one cycle, go IDLE.
REQ-011 m_resp_valid arriving in IDLE or ISSUE SHALL be ignored.
REQ-012 Requesters drop req_valid on the edge where their resp_valid is high; arbiter re-arbitrates only from IDLE, so min request-to-request spacing is 3 cycles (IDLE, ISSUE, WAIT).
REQ-013 req_valid deasserted after grant SHALL NOT cancel the transaction; response still issued.
REQ-014 Winner fields latched only in IDLE; later changes on req_* ignored.
REQ-015 grant_id=3 in IDLE; holds winner index in ISSUE and WAIT.

Reset
REQ-016 rst_n low asynchronously forces IDLE, m_valid=0, resp_valid=0, resp_err=0, grant_id=3, m_* regs=0, counter=0, RR pointer=0.
REQ-017 Reset mid-ISSUE/WAIT drops the transaction with no response; first grant after release is from IDLE.
REQ-018 Outputs defined by rst_n alone; no clock edge needed.

Configuration
REQ-019 Exactly one feature compile-selected.
REQ-020 ARB_RR_EN defined: round-robin; pointer holds last winner, search starts at pointer+1 modulo NREQ, pointer updates on each IDLE->ISSUE. Undefined: fixed priority per REQ-006, no pointer register.

Verification
REQ-021 Single read: req_valid=3'b001, addr 0x80000000; m_ready=1 in ISSUE, m_resp_valid with 0xDEADBEEF 2 cycles later -> m_addr=0x80000000, resp_valid=3'b001, resp_data=0xDEADBEEF.
REQ-022 Simultaneous req_valid=3'b111, no macro -> grant order 2,1,0; with ARB_RR_EN from reset -> 1,2,0.
REQ-023 Backpressure: m_ready=0 for 5 cycles -> m_valid high 6 cycles, m_addr/m_wdata unchanged throughout.
REQ-024 Timeout: no m_resp_valid for 255 WAIT cycles -> resp_valid pulse, resp_err=1, resp_data=0, grant_id=3 next cycle.
REQ-025 Reset in WAIT: rst_n low mid-transaction -> m_valid=0, grant_id=3 immediately, no resp_valid; late m_resp_valid ignored.
REQ-026 Write: req_valid=3'b010, wen=1, wdata 0x1122334455667788, strb 0xFF -> m_wen=1, identical m_wdata/m_strb.

Source files
------------

// File: rtl/bus_arbiter.sv
// Single-outstanding bus arbiter: NREQ requesters share one downstream port through an IDLE/ISSUE/WAIT FSM.
// Default arbitration is fixed priority (highest index wins); defining ARB_RR_EN selects round-robin instead.
module bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*64-1:0]   req_wdata,
    input  logic [NREQ*8-1:0]    req_strb,
    output logic [NREQ-1:0]      resp_valid,
    output logic [63:0]          resp_data,
    output logic                 resp_err,
    output logic [1:0]           grant_id,
    output logic                 m_valid,
    output logic [63:0]          m_addr,
    output logic                 m_wen,
    output logic [63:0]          m_wdata,
    output logic [7:0]           m_strb,
    input  logic                 m_ready,
    input  logic                 m_resp_valid,
    input  logic [63:0]          m_resp_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [1:0] GRANT_NONE  = 2'd3;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e          state_q, state_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic            m_valid_q, m_valid_d;
    logic [63:0]     m_addr_q, m_addr_d;
    logic            m_wen_q, m_wen_d;
    logic [63:0]     m_wdata_q, m_wdata_d;
    logic [7:0]      m_strb_q, m_strb_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            win_found_s;
    logic [1:0]      win_idx_s;
    logic [63:0]     win_addr_s;
    logic            win_wen_s;
    logic [63:0]     win_wdata_s;
    logic [7:0]      win_strb_s;
    logic [NREQ-1:0] grant_oh_s;
    logic            grant_fire_s;
    logic            issue_done_s;
    logic            tmo_s;
    logic            resp_done_s;

    assign win_found_s = |req_valid;

`ifdef ARB_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    int         rr_dist_s;
    int         rr_best_s;
    logic       rr_take_s;

    // Round-robin pick: requester with the smallest forward distance from the slot after the last winner.
    always_comb begin
        win_idx_s = 2'd0;
        rr_dist_s = 0;
        rr_best_s = NREQ;
        rr_take_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rr_dist_s = (i + NREQ - 1 - int'(rr_ptr_q)) % NREQ;
            rr_take_s = req_valid[i] && (rr_dist_s < rr_best_s);
            rr_best_s = rr_take_s ? rr_dist_s : rr_best_s;
            win_idx_s = rr_take_s ? 2'(i) : win_idx_s;
        end
    end

    // Pointer only moves when a grant is actually taken out of IDLE.
    always_comb begin
        if (grant_fire_s) begin
            rr_ptr_d = win_idx_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority pick: the highest requesting index wins.
    always_comb begin
        win_idx_s = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            win_idx_s = req_valid[i] ? 2'(i) : win_idx_s;
        end
    end
`endif

    // Gather the winning requester's fields from the packed request buses.
    always_comb begin
        win_addr_s  = 64'd0;
        win_wen_s   = 1'b0;
        win_wdata_s = 64'd0;
        win_strb_s  = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            win_addr_s  = (win_idx_s == 2'(i)) ? req_addr[i*64 +: 64]  : win_addr_s;
            win_wen_s   = (win_idx_s == 2'(i)) ? req_wen[i]            : win_wen_s;
            win_wdata_s = (win_idx_s == 2'(i)) ? req_wdata[i*64 +: 64] : win_wdata_s;
            win_strb_s  = (win_idx_s == 2'(i)) ? req_strb[i*8 +: 8]    : win_strb_s;
        end
    end

    // One-hot decode of the current owner for the response strobe.
    always_comb begin
        grant_oh_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant_oh_s[i] = (grant_id_q == 2'(i));
        end
    end

    assign grant_fire_s = (state_q == ST_IDLE)  && win_found_s;
    assign issue_done_s = (state_q == ST_ISSUE) && m_ready;
    assign tmo_s        = (state_q == ST_WAIT)  && !m_resp_valid && (cnt_q == TIMEOUT_CNT);
    assign resp_done_s  = (state_q == ST_WAIT)  && (m_resp_valid || (cnt_q == TIMEOUT_CNT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a response in WAIT (real or timeout) always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = win_found_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = m_ready     ? ST_WAIT  : ST_ISSUE;
            ST_WAIT:  state_d = resp_done_s ? ST_IDLE  : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured only on the IDLE grant, so later req_* changes cannot disturb them.
    always_comb begin
        grant_id_d = grant_id_q;
        m_valid_d  = m_valid_q;
        m_addr_d   = m_addr_q;
        m_wen_d    = m_wen_q;
        m_wdata_d  = m_wdata_q;
        m_strb_d   = m_strb_q;
        cnt_d      = cnt_q;
        if (grant_fire_s) begin
            grant_id_d = win_idx_s;
            m_valid_d  = 1'b1;
            m_addr_d   = win_addr_s;
            m_wen_d    = win_wen_s;
            m_wdata_d  = win_wdata_s;
            m_strb_d   = win_strb_s;
            cnt_d      = 8'd0;
        end else if (issue_done_s) begin
            m_valid_d = 1'b0;
            cnt_d     = 8'd0;
        end else if (resp_done_s) begin
            grant_id_d = GRANT_NONE;
            cnt_d      = 8'd0;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id_q <= GRANT_NONE;
            m_valid_q  <= 1'b0;
            m_addr_q   <= 64'd0;
            m_wen_q    <= 1'b0;
            m_wdata_q  <= 64'd0;
            m_strb_q   <= 8'd0;
            cnt_q      <= 8'd0;
        end else begin
            grant_id_q <= grant_id_d;
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_wen_q    <= m_wen_d;
            m_wdata_q  <= m_wdata_d;
            m_strb_q   <= m_strb_d;
            cnt_q      <= cnt_d;
        end
    end

    // Response path is combinational from the downstream response while waiting.
    always_comb begin
        resp_valid = {NREQ{1'b0}};
        resp_data  = 64'd0;
        resp_err   = 1'b0;
        if ((state_q == ST_WAIT) && m_resp_valid) begin
            resp_valid = grant_oh_s;
            resp_data  = m_resp_data;
        end else if (tmo_s) begin
            resp_valid = grant_oh_s;
            resp_err   = 1'b1;
        end else begin
            resp_valid = {NREQ{1'b0}};
        end
    end

    assign grant_id = grant_id_q;
    assign m_valid  = m_valid_q;
    assign m_addr   = m_addr_q;
    assign m_wen    = m_wen_q;
    assign m_wdata  = m_wdata_q;
    assign m_strb   = m_strb_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then randomized traffic against a
// requester-level model (pending mask, priority/rotation rule, one transaction at a time).
module tb_bus_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 255;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*64-1:0]   req_addr = '0;
    logic [NREQ-1:0]      req_wen = '0;
    logic [NREQ*64-1:0]   req_wdata = '0;
    logic [NREQ*8-1:0]    req_strb = '0;
    logic [NREQ-1:0]      resp_valid;
    logic [63:0]          resp_data;
    logic                 resp_err;
    logic [1:0]           grant_id;
    logic                 m_valid;
    logic [63:0]          m_addr;
    logic                 m_wen;
    logic [63:0]          m_wdata;
    logic [7:0]           m_strb;
    logic                 m_ready = 1'b0;
    logic                 m_resp_valid = 1'b0;
    logic [63:0]          m_resp_data = '0;

    int total = 0;
    int bad   = 0;
    int last_win = 0;

    logic [63:0] f_addr  [NREQ];
    logic        f_wen   [NREQ];
    logic [63:0] f_wdata [NREQ];
    logic [7:0]  f_strb  [NREQ];

    bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .grant_id(grant_id),
        .m_valid(m_valid), .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_strb(m_strb),
        .m_ready(m_ready), .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*64 +: 64]  = f_addr[i];
            req_wen[i]            = f_wen[i];
            req_wdata[i*64 +: 64] = f_wdata[i];
            req_strb[i*8 +: 8]    = f_strb[i];
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < NREQ; i++) begin
            f_addr[i]  = {$urandom(), $urandom()};
            f_wen[i]   = 1'($urandom_range(0, 1));
            f_wdata[i] = {$urandom(), $urandom()};
            f_strb[i]  = 8'($urandom());
        end
        drive_fields();
    endtask

    // Reference arbitration rule on the set of pending requesters.
    function automatic int pick(input logic [NREQ-1:0] m);
        int w;
        w = -1;
`ifdef ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last_win + k) % NREQ;
            if (w < 0 && m[c]) w = c;
        end
`else
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w < 0 && m[k]) w = k;
        end
`endif
        return w;
    endfunction

    task automatic do_reset();
        req_valid    = '0;
        m_ready      = 1'b0;
        m_resp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 64'(grant_id), 64'd3);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk("rst_m_strb", 64'(m_strb), 64'd0);
        tick();
        rst_n = 1'b1;
        last_win = 0;
    endtask

    // One complete transaction starting in IDLE with req_valid already driven.
    task automatic run_txn(input int bp, input int lat, input bit drop_early, input bit tmo,
                           input logic [63:0] rdata, output int won);
        int w;
        logic [63:0] a, d;
        logic we;
        logic [7:0] s;
        logic [NREQ-1:0] oh;
        w  = pick(req_valid);
        won = w;
        a  = f_addr[w];
        we = f_wen[w];
        d  = f_wdata[w];
        s  = f_strb[w];
        oh = 3'b001 << w;
        tick();
        last_win = w;
        chk("grant", 64'(grant_id), 64'(w));
        chk("issue_m_valid", 64'(m_valid), 64'd1);
        chk("m_addr", m_addr, a);
        chk("m_wen", 64'(m_wen), 64'(we));
        chk("m_wdata", m_wdata, d);
        chk("m_strb", 64'(m_strb), 64'(s));
        if (drop_early) req_valid[w] = 1'b0;
        m_ready = (bp == 0);
        for (int c = 0; c < bp; c++) begin
            scramble();
            m_resp_valid = 1'b1;
            m_resp_data  = {$urandom(), $urandom()};
            #1;
            chk("issue_ignore_resp", 64'(resp_valid), 64'd0);
            tick();
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_m_addr", m_addr, a);
            chk("bp_m_wdata", m_wdata, d);
            chk("bp_grant", 64'(grant_id), 64'(w));
        end
        m_resp_valid = 1'b0;
        m_ready      = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("wait_m_valid", 64'(m_valid), 64'd0);
        chk("wait_grant", 64'(grant_id), 64'(w));
        if (tmo) begin
            m_resp_data = {$urandom(), $urandom()};
            for (int c = 0; c < TIMEOUT; c++) begin
                chk("tmo_quiet", 64'(resp_valid), 64'd0);
                tick();
            end
            chk("tmo_resp_valid", 64'(resp_valid), 64'(oh));
            chk("tmo_resp_err", 64'(resp_err), 64'd1);
            chk("tmo_resp_data", resp_data, 64'd0);
        end else begin
            for (int c = 1; c < lat; c++) begin
                chk("wait_quiet", 64'(resp_valid), 64'd0);
                tick();
            end
            m_resp_valid = 1'b1;
            m_resp_data  = rdata;
            #1;
            chk("resp_valid", 64'(resp_valid), 64'(oh));
            chk("resp_data", resp_data, rdata);
            chk("resp_err", 64'(resp_err), 64'd0);
        end
        tick();
        req_valid[w] = 1'b0;
        m_resp_valid = 1'b0;
        chk("back_idle_grant", 64'(grant_id), 64'd3);
        chk("back_idle_m_valid", 64'(m_valid), 64'd0);
        chk("back_idle_resp", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int w0, w1, w2, wx;
        scramble();
        do_reset();

        // Idle with no requests stays idle.
        tick();
        chk("idle_grant", 64'(grant_id), 64'd3);
        chk("idle_m_valid", 64'(m_valid), 64'd0);

        // Simultaneous requests from reset: order fixed by the arbitration scheme.
        scramble();
        req_valid = 3'b111;
        run_txn(0, 1, 1'b0, 1'b0, 64'h0123, w0);
        run_txn(0, 1, 1'b0, 1'b0, 64'h4567, w1);
        run_txn(0, 1, 1'b0, 1'b0, 64'h89ab, w2);
`ifdef ARB_RR_EN
        chk("order0", 64'(w0), 64'd1);
        chk("order1", 64'(w1), 64'd2);
        chk("order2", 64'(w2), 64'd0);
`else
        chk("order0", 64'(w0), 64'd2);
        chk("order1", 64'(w1), 64'd1);
        chk("order2", 64'(w2), 64'd0);
`endif

        // Single read from IFU.
        scramble();
        f_addr[0] = 64'h0000_0000_8000_0000;
        f_wen[0]  = 1'b0;
        drive_fields();
        req_valid = 3'b001;
        run_txn(0, 2, 1'b0, 1'b0, 64'h0000_0000_DEAD_BEEF, wx);

        // Write from MEMU.
        scramble();
        f_wen[1]   = 1'b1;
        f_wdata[1] = 64'h1122_3344_5566_7788;
        f_strb[1]  = 8'hFF;
        drive_fields();
        req_valid = 3'b010;
        run_txn(0, 1, 1'b0, 1'b0, 64'h0, wx);

        // Backpressure for five cycles with scrambled inputs and stray responses.
        scramble();
        req_valid = 3'b100;
        run_txn(5, 3, 1'b0, 1'b0, 64'hCAFE_F00D_0000_0001, wx);

        // Requester withdraws after grant; response must still arrive.
        scramble();
        req_valid = 3'b001;
        run_txn(2, 1, 1'b1, 1'b0, 64'h5555_AAAA_5555_AAAA, wx);

        // Downstream never answers: timeout response.
        scramble();
        req_valid = 3'b010;
        run_txn(0, 0, 1'b0, 1'b1, 64'h0, wx);

        // Reset in WAIT drops the transaction; late response ignored.
        scramble();
        req_valid = 3'b010;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        #2 rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rstwait_m_valid", 64'(m_valid), 64'd0);
        chk("rstwait_grant", 64'(grant_id), 64'd3);
        chk("rstwait_resp", 64'(resp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        last_win = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("late_resp_ignored", 64'(resp_valid), 64'd0);
            chk("late_grant", 64'(grant_id), 64'd3);
        end
        m_resp_valid = 1'b0;

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            scramble();
            req_valid = req_valid | 3'($urandom_range(0, 7));
            if (req_valid == '0) begin
                tick();
                chk("rnd_idle_grant", 64'(grant_id), 64'd3);
                chk("rnd_idle_m_valid", 64'(m_valid), 64'd0);
            end else begin
                run_txn($urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                        1'b0, {$urandom(), $urandom()}, wx);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
